// File: rtl/fifo_scheduler.sv
// fifo_scheduler: round-robin write arbiter feeding a shared FIFO, plus a
// read sequencer that absorbs the FIFO's one-cycle registered read latency
// and presents words to a single consumer over valid/ready.
module fifo_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int LEVEL_W = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       fifo_write,
    output logic [WIDTH-1:0]           fifo_write_data,
    input  logic                       fifo_full,
    output logic                       fifo_read,
    input  logic [WIDTH-1:0]           fifo_read_data,
    input  logic                       fifo_empty,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       out_ready,
    output logic [LEVEL_W-1:0]         level,
    output logic [2:0]                 grant_id
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_VALID
    } state_t;

    localparam logic [3:0] NREQ = 4'(NUM_REQ);

    state_t                 r_state;
    state_t                 w_state_next;
    logic [2:0]             r_rr_ptr;
    logic [2:0]             r_grant_id;
    logic [LEVEL_W-1:0]     r_level;
    logic                   r_out_valid;
    logic [WIDTH-1:0]       r_out_data;

    logic [2*NUM_REQ-1:0]   w_req_dbl;
    logic [2*NUM_REQ-1:0]   w_req_rot;
    logic                   w_any;
    logic [2:0]             w_offset;
    logic [3:0]             w_sum;
    logic [2:0]             w_grant;
    logic                   w_write_en;
    logic                   w_load;
    logic                   w_clr;

    // Rotating the doubled request vector by rr_ptr turns the wrapped
    // search into a plain lowest-set-bit search starting at bit 0.
    assign w_req_dbl = {req_valid, req_valid};
    assign w_req_rot = w_req_dbl >> r_rr_ptr;

    // Find the first pending requester at or after rr_ptr
    always_comb begin
        w_any    = 1'b0;
        w_offset = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!w_any && w_req_rot[i]) begin
                w_any    = 1'b1;
                w_offset = i[2:0];
            end
        end
    end

    assign w_sum      = {1'b0, r_rr_ptr} + {1'b0, w_offset};
    assign w_grant    = (w_sum >= NREQ) ? 3'(w_sum - NREQ) : w_sum[2:0];
    assign w_write_en = w_any && !fifo_full && !reset;
    assign fifo_write = w_write_en;

    // Decode the grant into the one-hot ready and the write data mux
    always_comb begin
        req_ready       = '0;
        fifo_write_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (i[2:0] == w_grant) begin
                req_ready[i]    = w_write_en;
                fifo_write_data = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Advance the round-robin pointer past each accepted requester
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr   <= '0;
            r_grant_id <= '0;
        end else if (w_write_en) begin
            r_grant_id <= w_grant;
            r_rr_ptr   <= (w_grant == 3'(NUM_REQ - 1)) ? '0 : w_grant + 3'd1;
        end
    end

    // Read sequencer state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Read sequencer next state and read strobe
    always_comb begin
        w_state_next = r_state;
        fifo_read    = 1'b0;
        w_load       = 1'b0;
        w_clr        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!fifo_empty && !reset) begin
                    fifo_read    = 1'b1;
                    w_state_next = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                w_load       = 1'b1;
                w_state_next = S_VALID;
            end
            S_VALID: begin
                if (out_ready) begin
                    w_clr = 1'b1;
                    if (!fifo_empty && !reset) begin
                        fifo_read    = 1'b1;
                        w_state_next = S_CAPTURE;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Output holding register loaded one cycle after each FIFO read
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= fifo_read_data;
        end else if (w_clr) begin
            r_out_valid <= 1'b0;
        end
    end

    // Occupancy tracking; a write and a read in one cycle cancel out
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_level <= '0;
        end else begin
            case ({fifo_write, fifo_read})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign level     = r_level;
    assign grant_id  = r_grant_id;

endmodule

// File: doc/fifo_scheduler.md
# fifo_scheduler

Round-robin write arbiter and read sequencer for the peripheral FIFO. It shares one FIFO write port among NUM_REQ requesters and drains the FIFO to a single downstream consumer over a valid/ready handshake. It hides the FIFO's one-cycle registered read latency. It sits between bus-side producers (CPU store path, DMA) and a serial peripheral transmitter (e.g. UART TX).

## Interface
Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- WIDTH, 8: data word width; must match the attached FIFO.
- LEVEL_W, 6: width of the occupancy counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  requester i has a word.
- req_data  in  NUM_REQ*WIDTH  word of requester i at bits [i*WIDTH +: WIDTH].
- req_ready  out  NUM_REQ  one-hot grant; word i is accepted this cycle.
- fifo_write  out  1  FIFO write strobe.
- fifo_write_data  out  WIDTH  granted requester's word.
- fifo_full  in  1  FIFO full flag.
- fifo_read  out  1  FIFO read strobe.
- fifo_read_data  in  WIDTH  FIFO registered read data, valid the cycle after fifo_read.
- fifo_empty  in  1  FIFO empty flag.
- out_valid  out  1  out_data holds a word.
- out_data  out  WIDTH  word to the consumer.
- out_ready  in  1  consumer accepts the word.
- level  out  LEVEL_W  scheduler-tracked FIFO occupancy.
- grant_id  out  3  index of the last accepted requester.

## Operation
- Write arbitration is combinational:
  - When fifo_full=0 and any req_valid is set, grant the first set bit at or after rr_ptr, searching upward with wrap.
  - On a grant: req_ready[g]=1, fifo_write=1, fifo_write_data=req_data[g].
  - On the clock edge: rr_ptr <= (g==NUM_REQ-1) ? 0 : g+1, and grant_id <= g.
- When fifo_full=1 or no request is pending: req_ready=0, fifo_write=0, and rr_ptr/grant_id hold.
- Requesters must hold req_valid and req_data stable until req_ready is seen.
- The read sequencer FSM has states IDLE, CAPTURE and VALID:
  - IDLE: fifo_read = !fifo_empty. If fifo_read, go to CAPTURE.
  - CAPTURE: fifo_read=0. out_data <= fifo_read_data, out_valid <= 1, go to VALID.
  - VALID: out_valid=1, out_data held stable. On out_ready with fifo_empty=0: fifo_read=1, out_valid <= 0, go to CAPTURE. On out_ready with fifo_empty=1: out_valid <= 0, go to IDLE. With out_ready=0: stay.
- fifo_read is never asserted while fifo_empty=1. fifo_write is never asserted while fifo_full=1.
- level update:
  - +1 on fifo_write only.
  - −1 on fifo_read only.
  - Unchanged when both or neither occur in a cycle.
  - Width-truncated, but it never wraps in legal use.
- The FIFO must be wired to the same clk/reset nets.

## Timing
- Reset values (asynchronous, immediate): state=IDLE, rr_ptr=0, grant_id=0, level=0, out_valid=0, out_data=0.
- Because req_ready and fifo_write are combinational with reset deasserted, they are 0 during reset.
- Reset mid-operation:
  - A word held in out_data is discarded, and so is any word in CAPTURE.
  - No fifo_read or fifo_write is issued in the cycle reset is high.
- Write accepted in cycle t: fifo_empty falls in t+1, fifo_read is issued in t+1, CAPTURE runs in t+2, and out_valid=1 from t+3. Minimum latency is 3 cycles.
- Sustained throughput with out_ready=1 and the FIFO non-empty is 1 word per 2 cycles (VALID→CAPTURE→VALID).
- The write side can accept 1 word per cycle until the FIFO is full.
- Simultaneous fifo_write and fifo_read in one cycle are legal; level is unchanged.
- fifo_full rising blocks the grant in that same cycle. Requesters stall with req_ready=0 and lose no data.
- A requester dropping req_valid while not granted is legal; the next eligible requester wins.
- out_ready while out_valid=0 is ignored.

## Test plan
- Reset, then req_valid=4'b0001 with data 0x11 held for one grant, out_ready=1:
  - req_ready[0] in cycle 0.
  - out_valid=1, out_data=0x11 in cycle 3.
  - level goes 0→1→0.
- Round-robin with req_valid=4'b1111 held and distinct data 0xA0..0xA3:
  - Grants go 0,1,2,3,0 on consecutive cycles.
  - The output order on the consumer is A0,A1,A2,A3,A0.
- Round-robin skip with req_valid=4'b1010 after a grant to 1:
  - Next grant is 3, then 1.
  - grant_id follows 3,1.
- FIFO full with out_ready=0, writing until fifo_full=1:
  - req_ready and fifo_write stay 0.
  - level holds its maximum.
  - After raising out_ready, writes resume with no word lost or duplicated (scoreboard check).
- Consumer backpressure with out_ready=0 for 10 cycles while in VALID:
  - out_data is stable and fifo_read=0 throughout.
  - On out_ready=1, the next word appears 2 cycles later.
- Asynchronous reset asserted mid-CAPTURE:
  - out_valid=0, level=0 and state=IDLE immediately, without waiting for a clock edge.
  - After release, there are no spurious fifo_read/fifo_write strobes.
